// File: rtl/adc_spi_master_if.sv
// adc_spi_master_if
//   Pin- and datapath-side signals of the 3-wire ADC SPI master.
//   master modport : seen by adc_spi_master
//   slave  modport : seen by the ADC pins / sample consumer / controller
//   start, continuous : frame requests from the controller
//   MISO              : ADC DOUT
//   nCS, SCLK         : ADC chip select (active low) and serial clock (idles high)
//   sample, sample_valid, frame_err : 12-bit result, one-cycle strobe, framing status
//   busy              : block is not idle
interface adc_spi_master_if;
  logic        start;
  logic        continuous;
  logic        MISO;
  logic        nCS;
  logic        SCLK;
  logic [11:0] sample;
  logic        sample_valid;
  logic        frame_err;
  logic        busy;

  modport master (
    input  start, continuous, MISO,
    output nCS, SCLK, sample, sample_valid, frame_err, busy
  );

  modport slave (
    output start, continuous, MISO,
    input  nCS, SCLK, sample, sample_valid, frame_err, busy
  );
endinterface

// File: rtl/adc_spi_master.sv
// adc_spi_master
//   Reads one 16-SCLK frame from a 3-wire ADC (leading zero, 12-bit result
//   MSB first, two trailing zeros, hi-Z bit) and presents the result with a
//   one-cycle valid strobe and a framing-error flag.
//   CLK  : system clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : adc_spi_master_if.master (start, continuous, MISO in;
//          nCS, SCLK, sample, sample_valid, frame_err, busy out)
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | nCS high, SCLK high, waiting for start or continuous
//   CS_SETUP | nCS low, SCLK high for one half-period before first fall
//   SHIFT_LO | SCLK low half-period; MISO captured as SCLK rises
//   SHIFT_HI | SCLK high half-period; 16th one ends the frame
//   QUIET    | nCS high gap between frames
module adc_spi_master #(
  parameter int CLK_DIV      = 2,
  parameter int QUIET_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  adc_spi_master_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    QUIET    = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

  state_t      state_q,   state_d;
  logic [7:0]  div_q,     div_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q,   shift_d;
  logic        ncs_q,     ncs_d;
  logic        sclk_q,    sclk_d;
  logic [11:0] sample_q,  sample_d;
  logic        valid_q,   valid_d;
  logic        err_q,     err_d;

  logic div_tick;
  logic quiet_done;
  // The 16th bit may be hi-Z; it is kept only so the register holds the whole frame.
  logic unused_last_bit;

  // The divider doubles as the QUIET gap counter; it restarts on every state entry.
  assign div_tick        = (div_q == DIV_LAST);
  assign quiet_done      = (div_q == QUIET_LAST);
  assign unused_last_bit = shift_q[0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ncs_q     <= 1'b1;
      sclk_q    <= 1'b1;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ncs_q     <= ncs_d;
      sclk_q    <= sclk_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q + 8'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ncs_d     = ncs_q;
    sclk_d    = sclk_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (bus.start || bus.continuous) begin
          state_d = CS_SETUP;
          ncs_d   = 1'b0;
        end
      end

      CS_SETUP: begin
        if (div_tick) begin
          div_d     = '0;
          sclk_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        // Capture lands on the same edge that drives SCLK high.
        if (div_tick) begin
          div_d   = '0;
          shift_d = {shift_q[14:0], bus.MISO};
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end
      end

      SHIFT_HI: begin
        if (div_tick) begin
          div_d = '0;
          if (bit_cnt_q != 4'd15) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            sclk_d    = 1'b0;
            state_d   = SHIFT_LO;
          end else begin
            // shift_q[15] leading zero, [14:3] data, [2:1] trailing zeros.
            ncs_d    = 1'b1;
            valid_d  = 1'b1;
            sample_d = shift_q[14:3];
            err_d    = shift_q[15] | shift_q[2] | shift_q[1];
            state_d  = QUIET;
          end
        end
      end

      QUIET: begin
        if (quiet_done) begin
          div_d = '0;
          if (bus.continuous) begin
            state_d = CS_SETUP;
            ncs_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        div_d   = '0;
        ncs_d   = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  assign bus.nCS          = ncs_q;
  assign bus.SCLK         = sclk_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_err    = err_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
